// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path (and the future transmitter):
//   rx_state_t          receiver FSM states
//   OVERSAMPLE_DEFAULT  default number of baud ticks per bit
//   even_parity()       even-parity bit for a data byte
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam int OVERSAMPLE_DEFAULT = 16;

    // Bit that makes the total number of ones (data + parity) even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage : uart_pkg

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Enable-gated oversample tick generator. Counts 0..CLKS_PER_TICK-1 while en
// is high and emits tick on the wrap cycle; held at 0 while en is low so the
// first tick after enabling arrives exactly CLKS_PER_TICK clocks later.
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset
//   en     in   count enable
//   tick   out  one-cycle pulse every CLKS_PER_TICK enabled clocks
// -----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int CLKS_PER_TICK = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_TICK - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : uart_baud_gen

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// Oversampling UART receiver: start bit, 8 data bits LSB first, optional even
// parity, one stop bit. Bits are sampled at their midpoint. Received bytes are
// presented through a one-entry valid/ready holding register; framing, parity
// and overrun errors are single-cycle pulses.
// Build option: define UART_RX_PARITY_EN for 8E1 frames; otherwise 8N1 and
// parityErr is tied low.
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   uartRx     in   asynchronous serial line, idle high
//   data       out  received byte, stable while valid
//   valid      out  data holds an unconsumed byte
//   ready      in   consumer takes data when valid & ready
//   busy       out  frame reception in progress
//   frameErr   out  pulse: stop bit sampled low
//   parityErr  out  pulse: parity mismatch
//   overrun    out  pulse: good byte arrived while holding register full
// -----------------------------------------------------------------------------
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKFREQ       = 100_000_000,
    parameter int BAUDRATE      = 9600,
    parameter int OVERSAMPLE    = OVERSAMPLE_DEFAULT,
    parameter int CLKS_PER_TICK = CLKFREQ / (BAUDRATE * OVERSAMPLE)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uartRx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frameErr,
    output logic       parityErr,
    output logic       overrun
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] MID_CNT = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] END_CNT = SW'(OVERSAMPLE - 1);

    logic            sync1_q, rxs_q, rxs_prev_q;
    rx_state_t       state_q, state_d;
    logic [SW-1:0]   samp_q, samp_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            tick, baud_en, done;
`ifdef UART_RX_PARITY_EN
    logic            par_bad_q, par_bad_d;
    logic            parity_err_q, parity_err_d;
`endif

    // Tick counter only runs while a frame is being timed.
    assign baud_en = (state_q != IDLE) && (state_q != WAIT_HIGH);

    uart_baud_gen #(
        .CLKS_PER_TICK(CLKS_PER_TICK)
    ) u_baud_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (baud_en),
        .tick (tick)
    );

    always_comb begin
        state_d     = state_q;
        samp_d      = samp_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        done        = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        if (tick) begin
            samp_d = samp_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (rxs_prev_q && !rxs_q) begin
                    state_d = START;
                    samp_d  = '0;
                    bit_d   = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            START: begin
                if (tick && samp_q == MID_CNT) begin
                    if (rxs_q) begin
                        state_d = IDLE;           // glitch, not a real start bit
                    end else begin
                        samp_d  = '0;             // re-phase: later samples land mid-bit
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (tick && samp_q == END_CNT) begin
                    shift_d = {rxs_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick && samp_q == END_CNT) begin
                    par_bad_d = (rxs_q != even_parity(shift_q));
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (tick && samp_q == END_CNT) begin
                    if (!rxs_q) begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
                        state_d      = IDLE;
`endif
                    end else begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_HIGH: begin
                // A break holds the line low; wait it out before hunting edges.
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // One-entry holding register; a same-cycle handshake frees the slot.
        if (done) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q      <= 1'b1;
            rxs_q        <= 1'b1;
            rxs_prev_q   <= 1'b1;
            state_q      <= IDLE;
            samp_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1_q      <= uartRx;
            rxs_q        <= sync1_q;
            rxs_prev_q   <= rxs_q;
            state_q      <= state_d;
            samp_q       <= samp_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data     = data_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign frameErr = frame_err_q;
    assign overrun  = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parityErr = parity_err_q;
`else
    assign parityErr = 1'b0;
`endif

endmodule : uart_receiver

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Self-checking bench for uart_receiver at 1.6 MHz / 10 kbaud / x16 (160-clk
// bit). Frame outcomes are predicted from the frame contents and the consumer
// ready level; a negedge monitor collects delivered bytes and error pulses.
// Honors UART_RX_PARITY_EN to match the DUT build.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int BIT = 160;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uartRx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid, busy, frameErr, parityErr, overrun;

    always #5 clk = ~clk;

    uart_receiver #(
        .CLKFREQ   (1_600_000),
        .BAUDRATE  (10_000),
        .OVERSAMPLE(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .uartRx   (uartRx),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .busy     (busy),
        .frameErr (frameErr),
        .parityErr(parityErr),
        .overrun  (overrun)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int         n_fe = 0, n_pe = 0, n_ov = 0, n_vcyc = 0, n_got = 0;
    logic [7:0] got_mem [0:255];
    logic       prev_valid = 1'b0, prev_ready = 1'b0;

    always @(negedge clk) begin
        if (frameErr)  n_fe++;
        if (parityErr) n_pe++;
        if (overrun)   n_ov++;
        if (valid)     n_vcyc++;
        // A byte is new unless valid was already up and not taken last cycle.
        if (valid && !(prev_valid && !prev_ready)) begin
            if (n_got < 256) got_mem[n_got] = data;
            n_got++;
        end
        prev_valid = valid;
        prev_ready = ready;
    end

    // ---------------- helpers ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic ones_odd(input logic [7:0] d);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(d[i]);
        return (n % 2) == 1;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        uartRx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            uartRx = d[i];
            wait_clks(BIT);
        end
`ifdef UART_RX_PARITY_EN
        uartRx = par;
        wait_clks(BIT);
`else
        if (par) uartRx = 1'b1;   // no parity slot in 8N1
`endif
        uartRx = stop;
        wait_clks(BIT);
    endtask

    logic hold_full = 1'b0;   // model of the holding register occupancy

    // Sends a frame followed by one idle bit and checks it against the model.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic par,
                             input logic stop, input logic rdy);
        int fe0, pe0, ov0, g0;
        logic par_ok, exp_byte, exp_ov, exp_pe, exp_fe;
        fe0 = n_fe; pe0 = n_pe; ov0 = n_ov; g0 = n_got;
`ifdef UART_RX_PARITY_EN
        par_ok = (par == ones_odd(d));
`else
        par_ok = 1'b1;
`endif
        ready = rdy;
        if (rdy) hold_full = 1'b0;
        send_frame(d, par, stop);
        uartRx = 1'b1;
        wait_clks(BIT);
        exp_fe   = !stop;
        exp_pe   = stop && !par_ok;
        exp_byte = stop && par_ok && !hold_full;
        exp_ov   = stop && par_ok && hold_full;
        if (exp_byte) hold_full = !rdy;
        check({tag, "_fe"},  32'(n_fe - fe0), 32'(exp_fe));
        check({tag, "_pe"},  32'(n_pe - pe0), 32'(exp_pe));
        check({tag, "_ov"},  32'(n_ov - ov0), 32'(exp_ov));
        check({tag, "_got"}, 32'(n_got - g0), 32'(exp_byte));
        if (exp_byte && n_got > g0) check({tag, "_data"}, 32'(got_mem[g0]), 32'(d));
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int fe0, pe0, ov0, g0, v0;
        logic [7:0] d;

        // Reset state
        rst_n = 1'b0;
        wait_clks(4);
        check("rst_data",  32'(data), 32'h00);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_fe",    32'(frameErr), 32'd0);
        check("rst_pe",    32'(parityErr), 32'd0);
        check("rst_ov",    32'(overrun), 32'd0);
        rst_n = 1'b1;
        wait_clks(4);

        // 0xA5 with ready high: single valid cycle
        v0 = n_vcyc;
        run_frame("a5", 8'hA5, ones_odd(8'hA5), 1'b1, 1'b1);
        check("a5_vcyc", 32'(n_vcyc - v0), 32'd1);

        // 40-clk low glitch: false start
        fe0 = n_fe; pe0 = n_pe; ov0 = n_ov; g0 = n_got;
        uartRx = 1'b0;
        wait_clks(40);
        uartRx = 1'b1;
        wait_clks(10);
        check("glitch_busy_mid", 32'(busy), 32'd1);
        wait_clks(50);
        check("glitch_busy_end", 32'(busy), 32'd0);
        check("glitch_got", 32'(n_got - g0), 32'd0);
        check("glitch_err", 32'((n_fe - fe0) + (n_pe - pe0) + (n_ov - ov0)), 32'd0);

        // 0x3C with a low stop bit, line held low (break)
        fe0 = n_fe; g0 = n_got;
        send_frame(8'h3C, ones_odd(8'h3C), 1'b0);
        wait_clks(500);
        check("brk_busy_low", 32'(busy), 32'd1);
        check("brk_fe", 32'(n_fe - fe0), 32'd1);
        check("brk_got", 32'(n_got - g0), 32'd0);
        uartRx = 1'b1;
        wait_clks(BIT);
        check("brk_busy_rel", 32'(busy), 32'd0);
        run_frame("after_brk", 8'h55, ones_odd(8'h55), 1'b1, 1'b1);

        // Back-to-back 0x11, 0x22 with ready low: overrun on the second
        ov0 = n_ov; g0 = n_got;
        ready = 1'b0;
        send_frame(8'h11, ones_odd(8'h11), 1'b1);
        send_frame(8'h22, ones_odd(8'h22), 1'b1);
        uartRx = 1'b1;
        wait_clks(BIT);
        check("ovr_data",  32'(data), 32'h11);
        check("ovr_valid", 32'(valid), 32'd1);
        check("ovr_pulse", 32'(n_ov - ov0), 32'd1);
        check("ovr_got",   32'(n_got - g0), 32'd1);
        ready = 1'b1;
        wait_clks(1);
        ready = 1'b0;
        wait_clks(1);
        check("ovr_drain", 32'(valid), 32'd0);
        ready = 1'b1;
        hold_full = 1'b0;

`ifdef UART_RX_PARITY_EN
        run_frame("par_ok",  8'h07, 1'b1, 1'b1, 1'b1);
        run_frame("par_bad", 8'h07, 1'b0, 1'b1, 1'b1);
`endif

        // Reset during data bit 3 with a byte held
        run_frame("hold", 8'h99, ones_odd(8'h99), 1'b1, 1'b0);
        check("hold_valid", 32'(valid), 32'd1);
        d = 8'hC3;
        uartRx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 3; i++) begin
            uartRx = d[i];
            wait_clks(BIT);
        end
        uartRx = d[3];
        wait_clks(BIT / 2);
        rst_n = 1'b0;
        uartRx = 1'b1;
        wait_clks(1);
        check("mid_rst_data",  32'(data), 32'h00);
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_busy",  32'(busy), 32'd0);
        check("mid_rst_err",   32'({frameErr, parityErr, overrun}), 32'd0);
        rst_n = 1'b1;
        hold_full = 1'b0;
        ready = 1'b1;
        wait_clks(2 * BIT);
        run_frame("post_rst", 8'h5A, ones_odd(8'h5A), 1'b1, 1'b1);

        // Randomized frames against the model
        for (int k = 0; k < 16; k++) begin
            logic [7:0] rd;
            logic rp, rs, rr;
            rd = 8'($urandom_range(0, 255));
            rp = ones_odd(rd) ^ ($urandom_range(0, 5) == 0);
            rs = ($urandom_range(0, 5) != 0);
            rr = ($urandom_range(0, 2) != 0);
            run_frame($sformatf("rnd%0d", k), rd, rp, rs, rr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart_receiver

// File: doc/uart_receiver.md
# uart_receiver

Asynchronous serial receiver that sits downstream of the rover's UART transmit stage. It recovers 8-bit frames (start bit, 8 data bits LSB first, optional even parity, one stop bit) from an idle-high serial line and samples each bit at mid-point using an oversampled baud tick. Each byte goes to fabric logic through a one-entry valid/ready holding register. Framing, parity and overrun errors are reported as single-cycle pulses.

## Interface
Parameters:
- CLKFREQ, 100_000_000, system clock frequency in Hz
- BAUDRATE, 9600, line bit rate
- OVERSAMPLE, 16, baud ticks per bit (power of two, ≥8)
- CLKS_PER_TICK, CLKFREQ/(BAUDRATE*OVERSAMPLE), clocks per oversample tick

Ports:
- clk  input  1  system clock, all logic on posedge
- rst_n  input  1  synchronous active-low reset
- uartRx  input  1  asynchronous serial line, idle high
- data  output  8  received byte, stable while valid
- valid  output  1  data holds an unconsumed byte
- ready  input  1  consumer accepts data when valid&ready
- busy  output  1  frame reception in progress (state≠IDLE)
- frameErr  output  1  one-cycle pulse: stop bit sampled low
- parityErr  output  1  one-cycle pulse: parity mismatch (0 when parity compiled out)
- overrun  output  1  one-cycle pulse: byte completed while holding register full

## Operation
- uartRx passes through a 2-flop synchronizer. All decisions use the synchronized value rxs.
- Tick counter counts 0..CLKS_PER_TICK-1 and emits a tick on wrap. It is held at 0 in IDLE and WAIT_HIGH. Sample counter is log2(OVERSAMPLE) bits and increments on tick. Bit counter is 3 bits.
- States:
  - IDLE: a falling edge on rxs (1→0) goes to START and clears the counters.
  - START: at sample count OVERSAMPLE/2-1, if rxs=1 (false start) go to IDLE. Otherwise clear the sample counter and go to DATA.
  - DATA: at each sample count OVERSAMPLE-1, shift rxs into shift[7] (LSB-first right shift). After bit 7, go to PARITY if compiled in, else STOP.
  - PARITY: sample at OVERSAMPLE-1 and compare with the even parity of shift.
  - STOP: sample at OVERSAMPLE-1.
    - rxs=0: pulse frameErr, discard the byte, go to WAIT_HIGH.
    - rxs=1 with parity error: pulse parityErr, discard, go to IDLE.
    - Otherwise complete the byte and go to IDLE.
  - WAIT_HIGH: stay until rxs=1 (handles break), then go to IDLE.
- Byte completion:
  - If valid=0, or valid&ready in the same cycle, load data and set valid.
  - Else pulse overrun, discard the new byte, keep the old data.
- valid clears on valid&ready unless a new byte loads in the same cycle.
- Error pulses are mutually exclusive per frame. overrun is evaluated only for frames that pass stop and parity checks.

## Timing
- Reset values: data=0x00, valid=0, busy=0, frameErr=0, parityErr=0, overrun=0. The synchronizer resets to 1 so that no edge is detected immediately after reset.
- Reset is effective the cycle after rst_n is sampled low and aborts any frame mid-reception. A byte held in the register is lost.
- Line to rxs: 2 clk latency.
- The start-bit midpoint is sampled (OVERSAMPLE/2)·CLKS_PER_TICK clocks after the edge is detected. Each later sample follows one full bit period (OVERSAMPLE·CLKS_PER_TICK clocks) after the previous one.
- valid and error pulses assert on the clock after the stop-bit sample. busy falls on that same clock.
- A new start edge is accepted from the first IDLE cycle, so back-to-back frames are received with zero idle bits.

## Configuration
- UART_RX_PARITY_EN:
  - Defined: the PARITY state is present and each frame carries one even-parity bit before stop, so a frame is 11 bits. A mismatch pulses parityErr and drops the byte.
  - Undefined: frames are 8N1 (10 bits), the PARITY state is removed, and parityErr is tied to 0.

## Structure
- uart_pkg holds:
  - the rx_state_t enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH)
  - the OVERSAMPLE default
  - an even-parity function
- One sub-module, uart_baud_gen. It is an enable-gated tick counter parameterized by CLKS_PER_TICK, with ports clk, rst_n, en, tick, and is reusable by the transmitter.

## Test plan
Bench configuration: CLKFREQ=1_600_000, BAUDRATE=10_000, OVERSAMPLE=16, giving CLKS_PER_TICK=10 and a 160-clk bit.
- Drive 0xA5 as 8N1 with ready=1 → data=0xA5, valid high for 1 cycle, no error pulses, busy low afterwards.
- Low glitch of 40 clks, then high → no valid, no errors, busy returns to 0 about 80 clks after the edge.
- 0x3C with stop bit low, then line held low 500 clks → one frameErr pulse, no valid, busy stays high until the line rises, then the next 0x55 is received correctly.
- ready=0, send 0x11 then 0x22 back-to-back → data=0x11, valid stays 1, one overrun pulse at the end of the second frame. Then ready=1 for 1 cycle → valid=0.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 → valid, data=0x07. The same frame with parity bit 0 → one parityErr pulse, no valid.
- rst_n=0 for 1 clk during data bit 3 → all outputs zero next cycle. The following complete 0x5A frame is received as 0x5A.
